// File: rtl/seq_detect_param.sv
// seq_detect_param
//   Serial pattern detector. Watches a qualified one-bit stream for a
//   runtime-programmable PAT_LEN-bit pattern. On a match it emits a
//   one-cycle registered pulse and bumps a saturating match counter.
//   Supports overlapping and non-overlapping detection.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   qualifies `in`
//   in         serial data bit
//   pat        pattern; pat[PAT_LEN-1] is the first bit in time
//   overlap    1 = overlapping detection, 0 = non-overlapping
//   clear      synchronous flush of history, fill and counter (beats in_valid)
//   out        registered match pulse
//   match_cnt  saturating match count since reset/clear
//   cnt_sat    high while match_cnt is all ones
module seq_detect_param #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in,
    input  logic [PAT_LEN-1:0] pat,
    input  logic               overlap,
    input  logic               clear,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    localparam int FILL_W = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2
    } state_t;

    state_t              state_p0, state_d;
    logic [FILL_W-1:0]   fill_p0, fill_d;
    logic [PAT_LEN-1:0]  hist_p0, hist_d;
    logic [CNT_W-1:0]    cnt_p0, cnt_d;
    logic                out_p0, out_d;
    logic [PAT_LEN-1:0]  shifted;
    logic                hit;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == CNT_MAX) ? c : c + 1'b1;
    endfunction

    assign shifted = {hist_p0[PAT_LEN-2:0], in};

    // Stage p0: state, history, counter and match pulse registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_p0 <= IDLE;
            fill_p0  <= '0;
            hist_p0  <= '0;
            cnt_p0   <= '0;
            out_p0   <= 1'b0;
        end else begin
            state_p0 <= state_d;
            fill_p0  <= fill_d;
            hist_p0  <= hist_d;
            cnt_p0   <= cnt_d;
            out_p0   <= out_d;
        end
    end

    always_comb begin
        state_d = state_p0;
        fill_d  = fill_p0;
        hist_d  = hist_p0;
        cnt_d   = cnt_p0;
        out_d   = 1'b0;
        hit     = 1'b0;

        if (clear) begin
            // The bit presented alongside clear is deliberately dropped.
            state_d = IDLE;
            fill_d  = '0;
            hist_d  = '0;
            cnt_d   = '0;
        end else if (in_valid) begin
            hist_d = shifted;
            case (state_p0)
                IDLE: begin
                    fill_d  = FILL_W'(1);
                    state_d = (PAT_LEN == 2) ? ARMED : FILL;
                end
                FILL: begin
                    fill_d  = fill_p0 + 1'b1;
                    state_d = (fill_d == FILL_MAX) ? ARMED : FILL;
                end
                ARMED: begin
                    // Only armed once PAT_LEN bits have been taken, so the
                    // reset value of hist can never produce a false hit.
                    if (shifted == pat) begin
                        hit = 1'b1;
                        if (!overlap) begin
                            state_d = IDLE;
                            fill_d  = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    fill_d  = '0;
                end
            endcase
            if (hit) begin
                out_d = 1'b1;
                cnt_d = sat_inc(cnt_p0);
            end
        end
    end

    assign out       = out_p0;
    assign match_cnt = cnt_p0;
    assign cnt_sat   = (cnt_p0 == CNT_MAX);

endmodule
